mire_writer: RTL
================

# mire_writer

Wishbone write master on `sys_clk` that fills the SDRAM frame buffer with a selectable test pattern ("mire"). It sits directly upstream of the video stream stage: it drives the SDRAM Wishbone slave port of `hw_support`, and the video reader later fetches the frame from there. It paints one full frame per `start` request, then reports `done`.

## Interface
Parameters:
- `HDISP`, 800, pixels per line.
- `VDISP`, 480, lines per frame.
- `BASE_ADR`, 32'h0000_0000, byte address of pixel (0,0).
- `YIELD_LEN`, 64, accepted writes between bus releases (used only with `MIRE_YIELD_EN`).

Ports:
- `sys_clk`  in  1  system clock, 100 MHz.
- `sys_rst`  in  1  asynchronous, active-high reset.
- `start`  in  1  single-cycle request to paint one frame.
- `pat_sel`  in  2  pattern select, sampled on accepted `start`.
- `busy`  out  1  frame in progress.
- `done`  out  1  one-cycle pulse after the last pixel is acknowledged.
- `err_flag`  out  1  sticky; set on bus error, cleared by the next accepted `start`.
- `wb_cyc`, `wb_stb`, `wb_we`  out  1 each  Wishbone master controls.
- `wb_adr`  out  32  byte address.
- `wb_dat_ms`  out  32  write data `{8'h00,R,G,B}`.
- `wb_sel`  out  4  constant 4'hF while `wb_stb` is high, 0 otherwise.
- `wb_cti`, `wb_bte`  out  3/2  constant 0 (classic cycle).
- `wb_ack`, `wb_err`, `wb_rty`  in  1 each  slave responses.

## Operation
- States: IDLE, WRITE, YIELD, DONE.
- Reset (asynchronous): state IDLE. Reset values: `x`=`y`=0, `cyc`=`stb`=`we`=0, `adr`=`BASE_ADR`, `dat`=0, `busy`=`done`=`err_flag`=0. Reset during a frame aborts it immediately. There is no resume.
- IDLE: on `start`, latch `pat_sel`, clear `err_flag`, set x=y=0, go to WRITE.
- WRITE: `cyc`=`stb`=`we`=1.
  - On `ack`: advance x. At x=HDISP-1, x wraps to 0 and y increments.
  - After the last pixel is acked, go to DONE.
  - `rty`: beat is not accepted. Hold address and data, keep `stb` high.
  - `err`: set `err_flag`, drop `cyc`/`stb`, go to DONE. The frame is abandoned.
  - If `ack` and `err` arrive together, `err` wins.
- YIELD (only with `MIRE_YIELD_EN`): `cyc`=`stb`=0 for exactly 1 cycle, then back to WRITE.
- DONE: `done`=1 for 1 cycle, then IDLE.
- `busy` = (state != IDLE).
- `start` while busy is ignored.
- Address: `BASE_ADR + 4*(y*HDISP + x)`. Kept as a running +4 accumulator, with no multiplier. The accumulator wraps modulo 2^32.
- Patterns (8-bit R,G,B):
  - 0: solid white, FF,FF,FF.
  - 1: vertical bars, 8 colours, colour index = `x[6:4]` (bit2=R, bit1=G, bit0=B, each 00/FF).
  - 2: grid. White where `x[3:0]==0` or `y[3:0]==0`, black elsewhere.
  - 3: gradient, R=`x[7:0]`, G=`y[7:0]`, B=0.

## Timing
- `start` sampled at edge N -> `cyc`/`stb` high after edge N+1, with pixel (0,0) on the bus.
- Data and address for the next pixel are updated on the same edge that samples `ack`. A slave that acks every cycle gets back-to-back writes, so the minimum frame time is HDISP*VDISP cycles plus 2.
- `stb` never drops between beats except in YIELD, DONE, or on error.
- `done` is asserted the cycle after the final `ack` is sampled. `busy` falls one cycle later.
- Counter widths: x uses `$clog2(HDISP)` bits, y uses `$clog2(VDISP)` bits, the yield counter uses `$clog2(YIELD_LEN)` bits.

## Configuration
- `MIRE_YIELD_EN` defined:
  - After every `YIELD_LEN` accepted writes, the block enters YIELD and drops `cyc` for 1 cycle so other SDRAM masters can win arbitration.
  - No yield occurs after the final pixel.
- Undefined: `cyc` stays high continuously from the first to the last beat, and the YIELD state is not compiled.

## Structure
- Package `mire_pkg` holds:
  - `pixel_t`: packed struct with `pad`, `r`, `g`, `b`, 8 bits each.
  - `state_t`: enum of the states.
  - Pattern code localparams: `PAT_SOLID`, `PAT_BARS`, `PAT_GRID`, `PAT_GRAD`.
- Sub-module `mire_pattern_gen`: purely combinational, (x, y, pat) -> `pixel_t`. The FSM and counters stay in `mire_writer`.

## Test plan
Bench parameters: HDISP=16, VDISP=4, BASE_ADR=32'h100, YIELD_LEN=8.
- Ack every cycle, `pat_sel`=0 -> 64 writes, addresses 0x100 to 0x1FC step 4, all data 0x00FFFFFF, `done` at cycle 66 after `start`.
- `pat_sel`=3, random ack delays 0–5 cycles -> data at pixel (x,y) = `{8'h00, x, y, 8'h00}`, `stb` held steady while waiting for `ack`.
- `rty` on beat 5, then `ack` -> beat 5 is rewritten at the same address and data. 64 beats are accepted in total.
- `err` on beat 10 -> `cyc` low the next cycle, `err_flag`=1, `done` pulses. A new `start` clears `err_flag`.
- With `MIRE_YIELD_EN` defined -> `cyc` low for exactly 1 cycle after beats 8, 16, …, 56. Without it, `cyc` has no gap.
- `sys_rst` asserted at beat 20 -> all outputs go to reset values immediately. A following `start` restarts at 0x100.

Source files
------------

// File: rtl/mire_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mire_pkg
// Description : Shared types and pattern codes for the mire test-pattern
//               frame-buffer writer.
// Revision    : 1.0 - initial release
// ============================================================================
package mire_pkg;

  // One frame-buffer word: {pad, R, G, B}
  typedef struct packed {
    logic [7:0] pad;
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
  } pixel_t;

  // Writer sequencer states
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    YIELD = 2'd2,
    DONE  = 2'd3
  } state_t;

  // Pattern select codes
  localparam logic [1:0] PAT_SOLID = 2'd0;
  localparam logic [1:0] PAT_BARS  = 2'd1;
  localparam logic [1:0] PAT_GRID  = 2'd2;
  localparam logic [1:0] PAT_GRAD  = 2'd3;

  // Expand a single colour-enable bit to a full 8-bit channel
  function automatic logic [7:0] full_or_zero(input logic on);
    return on ? 8'hFF : 8'h00;
  endfunction

endpackage
`default_nettype wire

// File: rtl/mire_pattern_gen.sv
`default_nettype none
// ============================================================================
// Module      : mire_pattern_gen
// Description : Combinational pixel colour generator. Maps a pixel position
//               and pattern code onto a {pad,R,G,B} word.
// Revision    : 1.0 - initial release
// ============================================================================
module mire_pattern_gen import mire_pkg::*; #(
  parameter int XW = 10,
  parameter int YW = 9
) (
  input  logic [XW-1:0] x,
  input  logic [YW-1:0] y,
  input  logic [1:0]    pat,
  output pixel_t        pix
);

  // Coordinates are widened to at least 8 bits so that narrow frames still
  // yield well-defined bar and gradient bits (missing high bits read as 0).
  localparam int XE = (XW > 8) ? XW : 8;
  localparam int YE = (YW > 8) ? YW : 8;

  logic [XE-1:0] xe;
  logic [YE-1:0] ye;
  logic          grid_on;
  logic          unused_hi;

  assign xe        = XE'(x);
  assign ye        = YE'(y);
  assign grid_on   = (xe[3:0] == 4'h0) || (ye[3:0] == 4'h0);
  assign unused_hi = ^{xe, ye};

  // Colour selection for the current pattern
  always_comb begin
    pix     = '0;
    pix.pad = 8'h00;
    case (pat)
      PAT_SOLID: begin
        pix.r = 8'hFF;
        pix.g = 8'hFF;
        pix.b = 8'hFF;
      end
      PAT_BARS: begin
        pix.r = full_or_zero(xe[6]);
        pix.g = full_or_zero(xe[5]);
        pix.b = full_or_zero(xe[4]);
      end
      PAT_GRID: begin
        pix.r = full_or_zero(grid_on);
        pix.g = full_or_zero(grid_on);
        pix.b = full_or_zero(grid_on);
      end
      default: begin
        pix.r = xe[7:0];
        pix.g = ye[7:0];
        pix.b = 8'h00;
      end
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/mire_writer.sv
`default_nettype none
// ============================================================================
// Module      : mire_writer
// Description : Wishbone classic write master that paints one full test
//               pattern frame into the SDRAM frame buffer per start request.
//               Optional macro MIRE_YIELD_EN releases the bus for one cycle
//               after every YIELD_LEN accepted writes.
// Revision    : 1.0 - initial release
// ============================================================================
module mire_writer import mire_pkg::*; #(
  parameter int          HDISP     = 800,
  parameter int          VDISP     = 480,
  parameter logic [31:0] BASE_ADR  = 32'h0000_0000,
  parameter int          YIELD_LEN = 64
) (
  input  logic        sys_clk,
  input  logic        sys_rst,
  input  logic        start,
  input  logic [1:0]  pat_sel,
  output logic        busy,
  output logic        done,
  output logic        err_flag,
  output logic        wb_cyc,
  output logic        wb_stb,
  output logic        wb_we,
  output logic [31:0] wb_adr,
  output logic [31:0] wb_dat_ms,
  output logic [3:0]  wb_sel,
  output logic [2:0]  wb_cti,
  output logic [1:0]  wb_bte,
  input  logic        wb_ack,
  input  logic        wb_err,
  input  logic        wb_rty
);

  localparam int            XW     = $clog2(HDISP);
  localparam int            YW     = $clog2(VDISP);
  localparam logic [XW-1:0] X_LAST = XW'(HDISP - 1);
  localparam logic [YW-1:0] Y_LAST = YW'(VDISP - 1);
  localparam logic [XW-1:0] X_ONE  = XW'(1);
  localparam logic [YW-1:0] Y_ONE  = YW'(1);

`ifdef MIRE_YIELD_EN
  localparam int            KW     = $clog2(YIELD_LEN);
  localparam logic [KW-1:0] K_LAST = KW'(YIELD_LEN - 1);
  localparam logic [KW-1:0] K_ONE  = KW'(1);
  logic [KW-1:0] yld_q, yld_d;
`else
  localparam int unused_yield_len = YIELD_LEN;
`endif

  state_t        state_q, state_d;
  logic [XW-1:0] x_q, x_d;
  logic [YW-1:0] y_q, y_d;
  logic [1:0]    pat_q, pat_d;
  logic [31:0]   adr_q, adr_d;
  pixel_t        dat_q, dat_d;
  pixel_t        pix_next;
  logic          cyc_q, cyc_d;
  logic          stb_q, stb_d;
  logic          we_q, we_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          err_q, err_d;
  logic          load_pix;
  logic          last_pix;

  assign last_pix = (x_q == X_LAST) && (y_q == Y_LAST);

  // Colour of the pixel the next bus beat will carry
  mire_pattern_gen #(
    .XW (XW),
    .YW (YW)
  ) u_pattern (
    .x   (x_d),
    .y   (y_d),
    .pat (pat_d),
    .pix (pix_next)
  );

  // Sequencer next-state, pixel counters and Wishbone controls
  always_comb begin
    state_d  = state_q;
    x_d      = x_q;
    y_d      = y_q;
    pat_d    = pat_q;
    adr_d    = adr_q;
    cyc_d    = cyc_q;
    stb_d    = stb_q;
    we_d     = we_q;
    done_d   = 1'b0;
    err_d    = err_q;
    load_pix = 1'b0;
`ifdef MIRE_YIELD_EN
    yld_d    = yld_q;
`endif
    case (state_q)
      IDLE: begin
        cyc_d = 1'b0;
        stb_d = 1'b0;
        we_d  = 1'b0;
        if (start) begin
          pat_d    = pat_sel;
          err_d    = 1'b0;
          x_d      = '0;
          y_d      = '0;
          adr_d    = BASE_ADR;
          load_pix = 1'b1;
`ifdef MIRE_YIELD_EN
          yld_d    = '0;
`endif
          state_d  = WRITE;
        end
      end
      WRITE: begin
        // The first WRITE cycle only raises the strobe; responses count
        // only while a beat is actually presented.
        cyc_d = 1'b1;
        stb_d = 1'b1;
        we_d  = 1'b1;
        if (stb_q) begin
          if (wb_err) begin
            err_d   = 1'b1;
            cyc_d   = 1'b0;
            stb_d   = 1'b0;
            we_d    = 1'b0;
            done_d  = 1'b1;
            state_d = DONE;
          end else if (wb_rty) begin
            // Beat refused: hold address and data, strobe stays up
            state_d = WRITE;
          end else if (wb_ack) begin
            adr_d    = adr_q + 32'd4;
            load_pix = 1'b1;
            if (last_pix) begin
              x_d     = '0;
              y_d     = '0;
              cyc_d   = 1'b0;
              stb_d   = 1'b0;
              we_d    = 1'b0;
              done_d  = 1'b1;
              state_d = DONE;
            end else begin
              if (x_q == X_LAST) begin
                x_d = '0;
                y_d = y_q + Y_ONE;
              end else begin
                x_d = x_q + X_ONE;
              end
`ifdef MIRE_YIELD_EN
              if (yld_q == K_LAST) begin
                yld_d   = '0;
                cyc_d   = 1'b0;
                stb_d   = 1'b0;
                we_d    = 1'b0;
                state_d = YIELD;
              end else begin
                yld_d = yld_q + K_ONE;
              end
`endif
            end
          end
        end
      end
`ifdef MIRE_YIELD_EN
      YIELD: begin
        cyc_d   = 1'b1;
        stb_d   = 1'b1;
        we_d    = 1'b1;
        state_d = WRITE;
      end
`endif
      DONE: begin
        cyc_d   = 1'b0;
        stb_d   = 1'b0;
        we_d    = 1'b0;
        state_d = IDLE;
      end
      default: begin
        cyc_d   = 1'b0;
        stb_d   = 1'b0;
        we_d    = 1'b0;
        state_d = IDLE;
      end
    endcase
    busy_d = (state_d != IDLE);
  end

  // Write data advances together with the address on an accepted beat
  always_comb begin
    dat_d = load_pix ? pix_next : dat_q;
  end

  // State and output registers, asynchronously cleared
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      state_q <= IDLE;
      x_q     <= '0;
      y_q     <= '0;
      pat_q   <= PAT_SOLID;
      adr_q   <= BASE_ADR;
      dat_q   <= '0;
      cyc_q   <= 1'b0;
      stb_q   <= 1'b0;
      we_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
`ifdef MIRE_YIELD_EN
      yld_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      y_q     <= y_d;
      pat_q   <= pat_d;
      adr_q   <= adr_d;
      dat_q   <= dat_d;
      cyc_q   <= cyc_d;
      stb_q   <= stb_d;
      we_q    <= we_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      err_q   <= err_d;
`ifdef MIRE_YIELD_EN
      yld_q   <= yld_d;
`endif
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign err_flag  = err_q;
  assign wb_cyc    = cyc_q;
  assign wb_stb    = stb_q;
  assign wb_we     = we_q;
  assign wb_adr    = adr_q;
  assign wb_dat_ms = dat_q;
  assign wb_sel    = stb_q ? 4'hF : 4'h0;
  assign wb_cti    = 3'b000;
  assign wb_bte    = 2'b00;

endmodule
`default_nettype wire
